// File: rtl/pattern_seq_pkg.sv
// Shared definitions for the pattern sequencer: FSM state type,
// default geometry of the pattern buffers and a one-hot encode helper.
package pattern_seq_pkg;

  // Default geometry of the attached pattern buffer bank
  localparam int DEF_BUFFER_SIZE  = 22;
  localparam int DEF_BUFFER_WIDTH = 8;
  localparam int DEF_NO_BUFS      = 8;
  localparam int DEF_RD_LAT       = 2;

  // Widest one-hot vector the helper can produce
  localparam int OH_MAX_W = 64;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Index to one-hot; an index beyond OH_MAX_W-1 yields all zeros
  function automatic logic [OH_MAX_W-1:0] onehot(input logic [7:0] idx);
    logic [OH_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      if (idx == 8'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = v[i];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/pattern_seq_onehot_enc.sv
// Index to one-hot encoder with parameterised widths. An index that does
// not fit the output width produces an all-zero vector.
module onehot_enc
  import pattern_seq_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 22
) (
  input  logic [IN_W-1:0]  idx,
  output logic [OUT_W-1:0] oh
);

  // Truncate the shared helper's wide result to the requested width
  assign oh = OUT_W'(onehot(8'(idx)));

endmodule

// File: rtl/pattern_seq.sv
// Pattern sequencer: accepts write / readback burst commands and drives
// the one-hot buffer and field pointers of an external pattern buffer
// bank. Read data returns RD_LAT cycles after each field pointer issue.
module pattern_seq
  import pattern_seq_pkg::*;
#(
  parameter int BUFFER_SIZE  = DEF_BUFFER_SIZE,
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  parameter int NO_BUFS      = DEF_NO_BUFS,
  parameter int RD_LAT       = DEF_RD_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [2:0]              cmd_buf,
  input  logic [4:0]              cmd_first,
  input  logic [4:0]              cmd_count,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [BUFFER_WIDTH-1:0] wdata,
  output logic                    rdata_valid,
  output logic [BUFFER_WIDTH-1:0] rdata,
  output logic                    done,
  output logic                    err,
  output logic [7:0]              bufp,
  output logic [BUFFER_SIZE-1:0]  fieldp,
  output logic [BUFFER_SIZE-1:0]  fieldwp,
  output logic [BUFFER_WIDTH-1:0] field_in,
  output logic                    field_write,
  input  logic [BUFFER_WIDTH-1:0] field_byte
);

  state_t                  state_r, state_nxt_s;
  logic [4:0]              idx_r, idx_nxt_s;
  logic [4:0]              rem_r, rem_nxt_s;
  logic [7:0]              bufp_r, bufp_nxt_s;
  logic [BUFFER_SIZE-1:0]  fieldwp_r, fieldwp_nxt_s;
  logic [BUFFER_WIDTH-1:0] field_in_r, field_in_nxt_s;
  logic                    field_write_r, field_write_nxt_s;
  logic                    err_r, err_nxt_s;
  logic [RD_LAT-1:0]       vld_r, vld_nxt_s, vld_shift_s;

  logic [7:0]              buf_oh_s;
  logic [BUFFER_SIZE-1:0]  rd_oh_s;
  logic [BUFFER_SIZE-1:0]  wr_oh_s;
  logic [5:0]              span_s;
  logic                    buf_bad_s;
  logic                    cmd_bad_s;
  logic                    rd_issue_s;

  onehot_enc #(.IN_W(3), .OUT_W(8)) u_buf_enc (
    .idx (cmd_buf),
    .oh  (buf_oh_s)
  );

  onehot_enc #(.IN_W(5), .OUT_W(BUFFER_SIZE)) u_rd_enc (
    .idx (idx_r),
    .oh  (rd_oh_s)
  );

  onehot_enc #(.IN_W(5), .OUT_W(BUFFER_SIZE)) u_wr_enc (
    .idx (idx_r),
    .oh  (wr_oh_s)
  );

  // A 3-bit buffer index can never be out of range when all 8 buffers exist
  generate
    if (NO_BUFS >= 8) begin : g_all_bufs
      assign buf_bad_s = 1'b0;
    end else begin : g_some_bufs
      assign buf_bad_s = (cmd_buf >= 3'(NO_BUFS));
    end
  endgenerate

  // Range check is done 6 bits wide so first+count cannot wrap
  assign span_s     = {1'b0, cmd_first} + {1'b0, cmd_count};
  assign cmd_bad_s  = (cmd_count == 5'd0) || buf_bad_s ||
                      (span_s > 6'(BUFFER_SIZE));

  // One field is issued per cycle for as long as the FSM sits in READ
  assign rd_issue_s  = (state_r == READ);
  assign vld_shift_s = vld_r << 1;
  assign vld_nxt_s   = vld_shift_s | RD_LAT'(rd_issue_s);

  // Next-state and next-register values for the sequencer
  always_comb begin
    state_nxt_s       = state_r;
    idx_nxt_s         = idx_r;
    rem_nxt_s         = rem_r;
    bufp_nxt_s        = bufp_r;
    fieldwp_nxt_s     = '0;
    field_in_nxt_s    = '0;
    field_write_nxt_s = 1'b0;
    err_nxt_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad_s) begin
            err_nxt_s = 1'b1;
          end else begin
            bufp_nxt_s  = buf_oh_s;
            idx_nxt_s   = cmd_first;
            rem_nxt_s   = cmd_count;
            state_nxt_s = cmd_write ? WRITE : READ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          field_write_nxt_s = 1'b1;
          fieldwp_nxt_s     = wr_oh_s;
          field_in_nxt_s    = wdata;
          idx_nxt_s         = idx_r + 5'd1;
          rem_nxt_s         = rem_r - 5'd1;
          if (rem_r == 5'd1) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = WRITE;
          end
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        idx_nxt_s = idx_r + 5'd1;
        rem_nxt_s = rem_r - 5'd1;
        if (rem_r == 5'd1) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        // Leave once the last in-flight read has been presented
        if (vld_shift_s == '0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= 5'd0;
      rem_r         <= 5'd0;
      bufp_r        <= 8'b0000_0001;
      fieldwp_r     <= '0;
      field_in_r    <= '0;
      field_write_r <= 1'b0;
      err_r         <= 1'b0;
      vld_r         <= '0;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      rem_r         <= rem_nxt_s;
      bufp_r        <= bufp_nxt_s;
      fieldwp_r     <= fieldwp_nxt_s;
      field_in_r    <= field_in_nxt_s;
      field_write_r <= field_write_nxt_s;
      err_r         <= err_nxt_s;
      vld_r         <= vld_nxt_s;
    end
  end

  assign cmd_ready   = (state_r == IDLE);
  assign wdata_ready = (state_r == WRITE);
  assign done        = (state_r == DONE);
  assign err         = err_r;
  assign bufp        = bufp_r;
  assign fieldwp     = fieldwp_r;
  assign field_in    = field_in_r;
  assign field_write = field_write_r;
  assign fieldp      = rd_issue_s ? rd_oh_s : '0;

  // field_byte is valid exactly in the cycle the valid pipeline matures,
  // so it is passed through, gated, rather than registered a second time
  assign rdata_valid = vld_r[RD_LAT-1];
  assign rdata       = rdata_valid ? field_byte : '0;

endmodule

// File: tb/tb_pattern_seq.sv
// Self-checking bench for pattern_seq: a behavioural pattern buffer bank
// with RD_LAT read latency, a shadow copy of its contents, a table of
// directed commands, hand-written corner sequences and random commands.
module tb_pattern_seq;

  localparam int BS = 22;
  localparam int BW = 8;
  localparam int NB = 8;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [2:0]    cmd_buf;
  logic [4:0]    cmd_first;
  logic [4:0]    cmd_count;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [BW-1:0] wdata;
  logic          rdata_valid;
  logic [BW-1:0] rdata;
  logic          done;
  logic          err;
  logic [7:0]    bufp;
  logic [BS-1:0] fieldp;
  logic [BS-1:0] fieldwp;
  logic [BW-1:0] field_in;
  logic          field_write;
  logic [BW-1:0] field_byte;

  int checks   = 0;
  int failures = 0;

  logic       mem_init = 1'b1;
  logic [7:0] mem    [NB][BS];
  logic [7:0] shadow [NB][BS];
  logic [7:0] p1, p2;
  logic [7:0] exp_bufp;

  always #5 clk = ~clk;

  pattern_seq #(
    .BUFFER_SIZE(BS), .BUFFER_WIDTH(BW), .NO_BUFS(NB), .RD_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_buf(cmd_buf), .cmd_first(cmd_first), .cmd_count(cmd_count),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
    .bufp(bufp), .fieldp(fieldp), .fieldwp(fieldwp), .field_in(field_in),
    .field_write(field_write), .field_byte(field_byte)
  );

  function automatic logic [7:0] init_val(int b, int f);
    return 8'(8'hA0 + b * 24 + f);
  endfunction

  function automatic logic [BS-1:0] oh_f(int i);
    logic [BS-1:0] v;
    v = '0;
    if (i >= 0 && i < BS) v[i] = 1'b1;
    return v;
  endfunction

  // Behavioural pattern buffer bank: two-stage read pipeline
  assign field_byte = p2;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int b = 0; b < NB; b++)
        for (int f = 0; f < BS; f++)
          mem[b][f] <= init_val(b, f);
    end else if (field_write) begin
      for (int b = 0; b < NB; b++)
        for (int f = 0; f < BS; f++)
          if (bufp[b] && fieldwp[f]) mem[b][f] <= field_in;
    end
    p1 <= 8'h5A;
    for (int b = 0; b < NB; b++)
      for (int f = 0; f < BS; f++)
        if (bufp[b] && fieldp[f]) p1 <= mem[b][f];
    p2 <= p1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_bufp", bufp, 8'h01);
    check("rst_fieldp", fieldp, 0);
    check("rst_fieldwp", fieldwp, 0);
    check("rst_field_in", field_in, 0);
    check("rst_field_write", field_write, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wdata_ready", wdata_ready, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; wdata_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    exp_bufp = 8'h01;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
  endtask

  // Issue one command and check every cycle until done (or err)
  task automatic run_burst(input logic wr, input int b, input int f, input int c,
                           input bit gap, input bit exp_err, input bit rnd);
    int k, nhs, ndone, done_cyc, last_fw, budget, ri, pend_idx;
    bit fin, pend;
    logic [7:0] pend_byte, cur_byte, exp_b;
    logic [BS-1:0] exp_fp;
    logic exp_rv;
    wait_ready();
    exp_b = exp_err ? exp_bufp : 8'(32'd1 << b);
    cmd_valid = 1'b1; cmd_write = wr; cmd_buf = 3'(b);
    cmd_first = 5'(f); cmd_count = 5'(c);
    nhs = 0; ndone = 0; done_cyc = -1; last_fw = -1; k = 0; fin = 1'b0;
    budget = 3 * c + 20;
    cur_byte = rnd ? 8'($urandom) : 8'(f);
    while (!fin) begin
      if (wr) wdata_valid = (nhs < c) && (!gap || (k % 2 == 1));
      else    wdata_valid = 1'b0;
      wdata = cur_byte;
      pend = 1'b0;
      if (wdata_valid && wdata_ready) begin
        pend = 1'b1; pend_idx = f + nhs; pend_byte = cur_byte;
        if (f + nhs < BS) shadow[b][f + nhs] = cur_byte;
        nhs++;
        cur_byte = rnd ? 8'($urandom) : 8'(f + nhs);
      end
      @(negedge clk);
      k++;
      if (k == 1) cmd_valid = 1'b0;
      check("field_write", field_write, pend);
      if (pend) begin
        check("fieldwp", fieldwp, oh_f(pend_idx));
        check("field_in", field_in, pend_byte);
        last_fw = k;
      end else begin
        check("fieldwp_idle", fieldwp, 0);
      end
      check("wdata_ready", wdata_ready, wr && !exp_err && nhs < c);
      exp_fp = '0;
      if (!wr && !exp_err && k - 1 < c) exp_fp = oh_f(f + k - 1);
      check("fieldp", fieldp, exp_fp);
      ri = k - 1 - RL;
      exp_rv = !wr && !exp_err && ri >= 0 && ri < c;
      check("rdata_valid", rdata_valid, exp_rv);
      if (exp_rv) check("rdata", rdata, shadow[b][f + ri]);
      check("err", err, exp_err && k == 1);
      check("bufp", bufp, exp_b);
      if (done === 1'b1) begin
        ndone++;
        done_cyc = k;
        check("ready_in_done", cmd_ready, 0);
      end
      fin = exp_err ? (k >= 4) : (done_cyc > 0 || k >= budget);
    end
    wdata_valid = 1'b0;
    if (exp_err) begin
      check("err_no_done", ndone, 0);
    end else begin
      check("done_once", ndone, 1);
      if (wr) begin
        check("all_bytes", nhs, c);
        check("done_at_last_write", done_cyc, last_fw);
      end else begin
        check("done_after_rdata", (done_cyc > c + RL) && (done_cyc <= c + RL + 2), 1);
      end
      exp_bufp = exp_b;
    end
  endtask

  // cmd_valid held through done: next acceptance exactly one cycle later
  task automatic held_valid_seq();
    int k, dcyc;
    bit got;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_buf = 3'd5;
    cmd_first = 5'd2; cmd_count = 5'd2;
    dcyc = -1; k = 0;
    while (dcyc < 0 && k < 40) begin
      @(negedge clk); k++;
      if (done === 1'b1) dcyc = k;
    end
    check("held_done_seen", dcyc > 0, 1);
    check("held_ready_in_done", cmd_ready, 0);
    @(negedge clk);
    check("held_ready_after_done", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_second_accepted", cmd_ready, 0);
    got = 1'b0; k = 0;
    while (!got && k < 40) begin
      @(negedge clk); k++;
      if (done === 1'b1) got = 1'b1;
    end
    check("held_second_done", got, 1);
    exp_bufp = 8'h20;
  endtask

  // Reset during a readback after two field issues
  task automatic reset_mid_read();
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_buf = 3'd2;
    cmd_first = 5'd0; cmd_count = 5'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_read_issue2", fieldp, oh_f(1));
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_reset_outputs();
      if (i == 2) reset = 1'b0;
    end
    check("ready_after_abort", cmd_ready, 1);
    exp_bufp = 8'h01;
  endtask

  typedef struct {
    logic wr;
    int   b;
    int   f;
    int   c;
    bit   gap;
    bit   exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_buf = 3'd0;
    cmd_first = 5'd0; cmd_count = 5'd0; wdata_valid = 1'b0; wdata = 8'h00;
    exp_bufp = 8'h01;
    for (int b = 0; b < NB; b++)
      for (int f = 0; f < BS; f++)
        shadow[b][f] = init_val(b, f);

    vecs[0]  = '{1'b1, 3, 0, 22, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3, 4, 3, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3, 20, 3, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3, 5, 0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 6, 2, 5, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 6, 2, 5, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3, 19, 3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3, 21, 1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 0, 22, 1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 3, 0, 22, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 7, 31, 31, 1'b1, 1'b1};

    do_reset();

    for (int i = 0; i < 11; i++)
      run_burst(vecs[i].wr, vecs[i].b, vecs[i].f, vecs[i].c,
                vecs[i].gap, vecs[i].exp_err, 1'b0);

    held_valid_seq();
    reset_mid_read();

    for (int i = 0; i < 40; i++) begin
      logic rw;
      int rb, rf, rc;
      bit rg, re;
      rw = 1'($urandom_range(0, 1));
      rb = $urandom_range(0, NB - 1);
      rf = $urandom_range(0, 23);
      rc = $urandom_range(0, 23);
      if ($urandom_range(0, 3) != 0 && rf < BS) rc = $urandom_range(1, BS - rf);
      rg = 1'($urandom_range(0, 1));
      re = (rc == 0) || (rb >= NB) || (rf + rc > BS);
      run_burst(rw, rb, rf, rc, rg, re, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pattern_seq.md
PATTERN_SEQ -- requirements
Module: pattern_seq

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 22, number of fields per pattern buffer.
REQ-002 SHALL have parameter BUFFER_WIDTH, default 8, field byte width.
REQ-003 SHALL have parameter NO_BUFS, default 8, number of pattern buffers.
REQ-004 SHALL have parameter RD_LAT, default 2, cycles from fieldp drive to valid field_byte.
REQ-005 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = readback burst.
- cmd_buf  in  3  target buffer index.
- cmd_first  in  5  first field index.
- cmd_count  in  5  fields in burst, 1..BUFFER_SIZE.
- wdata_valid  in  1  write byte offered.
- wdata_ready  out  1  write byte taken when wdata_valid & wdata_ready.
- wdata  in  BUFFER_WIDTH  write byte.
- rdata_valid  out  1  readback byte valid; no backpressure.
- rdata  out  BUFFER_WIDTH  readback byte.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  one-cycle pulse on rejected command.
- bufp  out  8  one-hot buffer select to pattern buffer.
- fieldp  out  BUFFER_SIZE  one-hot read field pointer.
- fieldwp  out  BUFFER_SIZE  one-hot write field pointer.
- field_in  out  BUFFER_WIDTH  write data to pattern buffer.
- field_write  out  1  write strobe.
- field_byte  in  BUFFER_WIDTH  readback byte from pattern buffer.

Function
REQ-006 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE; cmd_ready = 1 only in IDLE.
REQ-007 On acceptance, SHALL reject the command (err pulse next cycle, remain IDLE, bufp unchanged) if cmd_count==0, cmd_buf>=NO_BUFS, or cmd_first+cmd_count>BUFFER_SIZE, computed 6-bit wide.
REQ-008 On a legal command, SHALL register bufp = one-hot(cmd_buf), load field index = cmd_first and remaining = cmd_count, then enter WRITE or READ per cmd_write.
REQ-009 In WRITE, wdata_ready SHALL be 1; each handshake SHALL drive field_write=1, fieldwp=one-hot(index), field_in=wdata for exactly the next cycle, then increment index and decrement remaining.
REQ-010 Without a wdata handshake, field_write and fieldwp SHALL be 0.
REQ-011 After the last write handshake, SHALL enter DONE.
REQ-012 In READ, SHALL drive fieldp=one-hot(index) for one cycle per field, back-to-back, one field per cycle.
REQ-013 SHALL assert rdata_valid with rdata=field_byte exactly RD_LAT cycles after each fieldp issue, tracked by a RD_LAT-deep valid shift register.
REQ-014 After the last issue, SHALL enter DRAIN (fieldp=0) until the shift register is empty, then DONE.
REQ-015 DONE SHALL assert done for one cycle and return to IDLE; bufp SHALL hold its value across IDLE.
REQ-016 Outside READ, fieldp SHALL be 0; outside WRITE, wdata_ready SHALL be 0.
REQ-017 A command offered in the cycle of done SHALL NOT be accepted; the earliest acceptance is the following cycle.

Reset
REQ-018 Reset SHALL force IDLE; bufp=8'b00000001; fieldp, fieldwp, field_in, field_write, rdata, rdata_valid, done, err, wdata_ready all 0; cmd_ready=1 the cycle after reset deasserts.
REQ-019 Reset mid-burst SHALL abort immediately, clear the read-valid pipeline, and produce no done.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, BUFFER_SIZE/BUFFER_WIDTH/NO_BUFS defaults and the one-hot encode function.
REQ-021 A sub-module onehot_enc (index to one-hot, parameterised width) SHALL be instantiated for bufp, fieldp and fieldwp.

Verification
REQ-022 Write buf 3, first 0, count 22, wdata 0x00..0x15 -> 22 field_write pulses, fieldwp walks bit 0..21, bufp=0x08, done once.
REQ-023 Readback buf 3, first 4, count 3, with a behavioural pattern buffer model -> rdata 0x04,0x05,0x06 on consecutive cycles starting RD_LAT after first fieldp, done after the last.
REQ-024 first 20, count 3 -> err pulse, no field_write, bufp unchanged; count 0 -> err.
REQ-025 Write burst with wdata_valid toggling every other cycle -> field_write only on handshake cycles, fieldwp 0 otherwise.
REQ-026 Reset asserted mid-READ after 2 issues -> no further rdata_valid, no done, all outputs at reset values.
REQ-027 cmd_valid held high through done -> second command accepted exactly one cycle after done.
